// File: rtl/nes_controller_emulator.sv
// rtl/nes_controller_emulator.sv - device-side NES pad: synchronised latch/clock into an 8-bit shift register
module nes_controller_emulator #(
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_BIT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic [7:0] buttons_i,
    input  logic       console_latch_i,
    input  logic       console_clk_i,
    output logic       console_serial_no,
    output logic [7:0] snapshot_o,
    output logic [3:0] bit_index_o,
    output logic       frame_done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_dly_q;
    logic                   clk_dly_q;

    logic [7:0] sr_q, sr_d;
    logic [7:0] snap_q, snap_d;
    logic [3:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       serial_q;

    logic latch_s, clk_s;
    logic latch_rise, latch_fall, clk_rise;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_dly_q;
    assign latch_fall = ~latch_s & latch_dly_q;
    assign clk_rise   = clk_s & ~clk_dly_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_dly_q  <= 1'b0;
            clk_dly_q    <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], console_latch_i};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], console_clk_i};
            latch_dly_q  <= latch_s;
            clk_dly_q    <= clk_s;
        end
    end

    // A latch rise wins over everything, including a clock rise in the same cycle.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (latch_rise) begin
            state_d = LATCH;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: ;
                LATCH: begin
                    if (latch_fall) begin
                        state_d = SHIFT;
                        snap_d  = sr_q;
                        idx_d   = 4'd0;
                    end else begin
                        sr_d = buttons_i;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sr_d  = {sr_q[6:0], FILL_BIT};
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (clk_rise) begin
                        sr_d = {sr_q[6:0], FILL_BIT};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sr_q     <= 8'h00;
            snap_q   <= 8'h00;
            idx_q    <= 4'd0;
            done_q   <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            serial_q <= ~sr_q[7];
        end
    end

    assign console_serial_no = serial_q;
    assign snapshot_o        = snap_q;
    assign bit_index_o       = idx_q;
    assign frame_done_o      = done_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb/tb_nes_controller_emulator.sv - directed-vector bench for nes_controller_emulator
module tb_nes_controller_emulator;

    logic       clk;
    logic       rst_ni;
    logic [7:0] buttons_i;
    logic       console_latch_i;
    logic       console_clk_i;
    logic       console_serial_no;
    logic [7:0] snapshot_o;
    logic [3:0] bit_index_o;
    logic       frame_done_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    nes_controller_emulator #(
        .SYNC_STAGES(2),
        .FILL_BIT   (1'b1)
    ) dut (
        .clk              (clk),
        .rst_ni           (rst_ni),
        .buttons_i        (buttons_i),
        .console_latch_i  (console_latch_i),
        .console_clk_i    (console_clk_i),
        .console_serial_no(console_serial_no),
        .snapshot_o       (snapshot_o),
        .bit_index_o      (bit_index_o),
        .frame_done_o     (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_pulse();
        console_latch_i = 1'b1;
        wait_cyc(8);
        console_latch_i = 1'b0;
        wait_cyc(8);
    endtask

    task automatic crise();
        console_clk_i = 1'b1;
        wait_cyc(8);
        console_clk_i = 1'b0;
        wait_cyc(8);
    endtask

    // serial_no after latch, then after rises 1..7
    bit exp_a1 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_3c [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_ni          = 1'b0;
        buttons_i       = 8'h00;
        console_latch_i = 1'b0;
        console_clk_i   = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            buttons_i       = 8'($urandom);
            console_latch_i = 1'($urandom);
            console_clk_i   = 1'($urandom);
        end
        chk("rst_serial", 8'(console_serial_no), 8'h01);
        chk("rst_snapshot", snapshot_o, 8'h00);
        chk("rst_bit_index", 8'(bit_index_o), 8'h00);
        chk("rst_frame_done", 8'(done_cnt), 8'h00);
        console_latch_i = 1'b0;
        console_clk_i   = 1'b0;
        buttons_i       = 8'h00;
        wait_cyc(2);
        rst_ni = 1'b1;
        wait_cyc(4);
        done_cnt = 0;

        // basic frame 0xA1
        buttons_i = 8'hA1;
        latch_pulse();
        chk("basic_snapshot", snapshot_o, 8'hA1);
        chk("basic_idx0", 8'(bit_index_o), 8'h00);
        chk("basic_bit0", 8'(console_serial_no), 8'(exp_a1[0]));
        for (int i = 1; i < 8; i++) begin
            crise();
            chk($sformatf("basic_bit%0d", i), 8'(console_serial_no), 8'(exp_a1[i]));
            chk($sformatf("basic_idx%0d", i), 8'(bit_index_o), 8'(i));
        end
        chk("basic_no_early_done", 8'(done_cnt), 8'h00);
        crise();
        chk("basic_done", 8'(done_cnt), 8'h01);
        chk("basic_idx8", 8'(bit_index_o), 8'h08);
        chk("basic_fill", 8'(console_serial_no), 8'h00);

        // overrun
        crise();
        crise();
        chk("over_fill", 8'(console_serial_no), 8'h00);
        chk("over_idx", 8'(bit_index_o), 8'h08);
        chk("over_done", 8'(done_cnt), 8'h01);

        // clock rises during latch are ignored
        done_cnt = 0;
        buttons_i = 8'h55;
        console_latch_i = 1'b1;
        wait_cyc(8);
        crise();
        crise();
        crise();
        console_latch_i = 1'b0;
        wait_cyc(8);
        chk("latchclk_idx", 8'(bit_index_o), 8'h00);
        chk("latchclk_bit0", 8'(console_serial_no), 8'h01);
        chk("latchclk_snapshot", snapshot_o, 8'h55);
        chk("latchclk_done", 8'(done_cnt), 8'h00);

        // relatch abort
        done_cnt = 0;
        buttons_i = 8'hA1;
        latch_pulse();
        crise();
        crise();
        crise();
        chk("abort_idx3", 8'(bit_index_o), 8'h03);
        buttons_i = 8'h3C;
        latch_pulse();
        chk("abort_no_done", 8'(done_cnt), 8'h00);
        chk("abort_idx0", 8'(bit_index_o), 8'h00);
        chk("abort_snapshot", snapshot_o, 8'h3C);
        chk("abort_bit0", 8'(console_serial_no), 8'(exp_3c[0]));
        for (int i = 1; i < 8; i++) begin
            crise();
            chk($sformatf("abort_bit%0d", i), 8'(console_serial_no), 8'(exp_3c[i]));
        end
        crise();
        chk("abort_done", 8'(done_cnt), 8'h01);

        // buttons change mid-frame, then async reset
        buttons_i = 8'hA1;
        latch_pulse();
        crise();
        crise();
        buttons_i = 8'hFF;
        for (int i = 3; i < 6; i++) begin
            crise();
            chk($sformatf("mid_bit%0d", i), 8'(console_serial_no), 8'(exp_a1[i]));
        end
        chk("mid_snapshot", snapshot_o, 8'hA1);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_serial", 8'(console_serial_no), 8'h01);
        chk("arst_idx", 8'(bit_index_o), 8'h00);
        chk("arst_snapshot", snapshot_o, 8'h00);
        wait_cyc(2);
        rst_ni = 1'b1;
        wait_cyc(4);
        crise();
        chk("post_rst_idx", 8'(bit_index_o), 8'h00);
        chk("post_rst_serial", 8'(console_serial_no), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_controller_emulator.md
Name: nes_controller_emulator

Overview:
Device-side NES controller model. It presents an 8-button state to an external console or host through the standard latch/clock/serial-data interface. Console latch and clock are asynchronous to clk; both are synchronised, edge-detected and used to drive an 8-bit parallel-load shift register whose MSB appears active-low on the serial line. Used to emulate pads toward real consoles and as a loopback target for the controller-reader path.

Parameters:
SYNC_STAGES, 2, flop stages on each console input (min 2)
FILL_BIT, 1, logical (active-high) value shifted in after 8 bits; 1 matches official pads (line reads low)

Ports:
clk  input  1  system clock; must be >= 8x console clock frequency
rst_ni  input  1  asynchronous active-low reset
buttons_i  input  8  live button state, active-high; bit7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right
console_latch_i  input  1  console latch, async, active-high
console_clk_i  input  1  console clock, async; shift on synchronised rising edge
console_serial_no  output  1  serial data, active-low (0 = pressed), driven directly from a flop
snapshot_o  output  8  buttons captured at latch falling edge
bit_index_o  output  4  bits shifted so far this frame, 0..8, saturating
frame_done_o  output  1  one-cycle pulse when the 8th bit is shifted out

Behaviour:
- Reset (async assert, sync release): all sync flops 0, shift reg 0, console_serial_no=1, snapshot_o=0, bit_index_o=0, frame_done_o=0, state IDLE.
- Sync: latch_s and clk_s are the last stage of SYNC_STAGES flops. Edge detect uses one extra delay flop: rise = s & ~d, fall = ~s & d.
- States:
  - IDLE: hold shift reg. Clock edges ignored. latch rise -> LATCH.
  - LATCH: shift reg <= buttons_i every cycle; clock rises ignored (hosts pulse clock during latch). latch fall -> SHIFT: snapshot_o <= shift reg, bit_index <= 0.
  - SHIFT: each clk_s rise: shift reg <= {sr[6:0], FILL_BIT}, bit_index++. On the rise that makes bit_index 8: frame_done_o=1 for one cycle, -> DONE.
  - DONE: further clock rises keep shifting FILL_BIT. bit_index holds 8. No further frame_done. latch rise -> LATCH.
- console_serial_no = ~sr[7] is registered, so it updates one cycle after the shift-register update.
- Latency: console edge to serial update is SYNC_STAGES+2 clk cycles max. A 8x clk ratio leaves >= half a console period of setup margin.
- Priority: a latch rise in any state wins over a simultaneous clock rise. Entering LATCH from SHIFT aborts the frame: no frame_done, bit_index <= 0.
- Changes to buttons_i outside LATCH never affect the frame in flight.
- Simultaneous latch fall and clock rise: take the latch fall; that clock edge is ignored.
- Async reset mid-frame returns everything to reset values immediately. The next frame needs a fresh latch.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> console_serial_no=1, snapshot_o=0x00, bit_index_o=0, frame_done_o never 1.
- Basic frame: buttons_i=0xA1, latch pulse, then 8 clock rises -> serial_no after latch and each rise 0,1,0,1,1,1,1,0 (last before 8th rise). snapshot_o=0xA1. frame_done_o single pulse after 8th rise. bit_index_o=8.
- Overrun: 2 extra rises after frame -> serial_no=0 (FILL_BIT=1), bit_index_o stays 8, no second frame_done_o.
- Clock during latch: 3 rises while latch high with buttons_i=0x55 -> ignored. After fall bit_index_o=0, first bit serial_no=1 (bit7=0).
- Relatch abort: 3 rises into frame of 0xA1, latch again with buttons_i=0x3C -> no frame_done_o. New frame serial_no 1,1,0,0,0,0,1,1. snapshot_o=0x3C.
- Buttons change mid-frame and async reset: flip buttons_i to 0xFF after rise 2 -> sequence unchanged. Then assert rst_ni mid-frame -> serial_no=1 same cycle, bit_index_o=0.
